// File: rtl/led_ctrl_pkg.sv
// Shared constants and helpers for the LED control button conditioner.
package led_ctrl_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 100000;
  localparam int DEBOUNCE_CYCLES_SIM     = 4;

  // Counter width for a debounce window of n cycles, never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-channel button conditioner: 2-flop synchronizer, optional inversion,
// stability counter, debounced level and a one-cycle press strobe.
module debounce_bit
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic stable,
  output logic press
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_reg;
  logic          s2_reg;
  logic          s;
  logic [CW-1:0] cnt_reg;
  logic          stable_reg;
  logic          press_reg;

  // Synchronizer; reset to the released level so the internal value reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg <= BTN_ACTIVE_LOW;
      s2_reg <= BTN_ACTIVE_LOW;
    end else begin
      s1_reg <= btn_raw;
      s2_reg <= s1_reg;
    end
  end

  // Pressed reads as 1 internally regardless of board polarity.
  assign s = s2_reg ^ BTN_ACTIVE_LOW;

  // Stability counter: accept s only after DEBOUNCE_CYCLES consecutive differing cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
      press_reg  <= 1'b0;
    end else begin
      press_reg <= 1'b0;
      if (s == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_MAX) begin
        cnt_reg    <= '0;
        stable_reg <= s;
        // Strobe only on an accepted 0->1; releases stay silent.
        press_reg  <= s;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign stable = stable_reg;
  assign press  = press_reg;

endmodule

// File: rtl/led_ctrl_debounce.sv
// Conditions raw board buttons into the led_ctrl bus.
// Build option LED_CTRL_TOGGLE_EN: when defined, each led_ctrl bit toggles on
// every press strobe; otherwise led_ctrl is a direct copy of btn_stable.
module led_ctrl_debounce
  import led_ctrl_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] btn_stable,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] led_ctrl
);

  // One independent conditioner per channel.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
      ) u_bit (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_in[gi]),
        .stable (btn_stable[gi]),
        .press  (btn_press[gi])
      );
    end
  endgenerate

`ifdef LED_CTRL_TOGGLE_EN
  logic [WIDTH-1:0] toggle_reg;

  // Press-to-toggle latch: flips one cycle after each strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      toggle_reg <= '0;
    end else begin
      toggle_reg <= toggle_reg ^ btn_press;
    end
  end

  assign led_ctrl = toggle_reg;
`else
  assign led_ctrl = btn_stable;
`endif

endmodule

// File: tb/tb_led_ctrl_debounce.sv
// Scoreboard bench for led_ctrl_debounce with a 4-cycle debounce window,
// active-low buttons. Expected outputs are queued against a cycle number
// when stimulus is driven and compared on the falling edge of that cycle.
module tb_led_ctrl_debounce;
  import led_ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] btn_stable;
  logic [3:0] btn_press;
  logic [3:0] led_ctrl;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  int         q_cyc[$];
  logic [3:0] q_st[$];
  logic [3:0] q_pr[$];
  logic [3:0] q_led[$];
  bit         q_chk[$];
  string      q_tag[$];

`ifdef LED_CTRL_TOGGLE_EN
  localparam bit LEVEL = 1'b0;
`else
  localparam bit LEVEL = 1'b1;
`endif

  led_ctrl_debounce #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES_SIM),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .btn_stable(btn_stable),
    .btn_press (btn_press),
    .led_ctrl  (led_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [3:0] st, input logic [3:0] pr,
                      input logic [3:0] led, input bit chk, input string tag);
    q_cyc.push_back(c);
    q_st.push_back(st);
    q_pr.push_back(pr);
    q_led.push_back(led);
    q_chk.push_back(chk);
    q_tag.push_back(tag);
  endtask

  // Level-build expectation: led_ctrl mirrors btn_stable.
  task automatic pushl(input int c, input logic [3:0] st, input logic [3:0] pr, input string tag);
    push(c, st, pr, st, LEVEL, tag);
  endtask

  task automatic run_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare queued expectations on the falling edge of their cycle.
  always @(negedge clk) begin
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      int         c;
      logic [3:0] st, pr, led;
      bit         chk;
      string      tag;
      c   = q_cyc.pop_front();
      st  = q_st.pop_front();
      pr  = q_pr.pop_front();
      led = q_led.pop_front();
      chk = q_chk.pop_front();
      tag = q_tag.pop_front();
      if (c < cyc) begin
        check({tag, "_missed"}, 32'(c), 32'(cyc));
      end else begin
        $display("txn cyc=%0d %s stable=%h press=%h led=%h", cyc, tag, btn_stable, btn_press, led_ctrl);
        check({tag, "_stable"}, 32'(btn_stable), 32'(st));
        check({tag, "_press"},  32'(btn_press),  32'(pr));
        if (chk) check({tag, "_led"}, 32'(led_ctrl), 32'(led));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected < 2000", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    logic [3:0] tog;
    rst    = 1'b1;
    btn_in = 4'h0;

    // Reset with all buttons held: outputs stay 0, press accepted 6 cycles after release.
    run_to(1);
    for (int i = 1; i <= 3; i++) push(i, 4'h0, 4'h0, 4'h0, 1'b1, "rst_hold");
    run_to(3);
    rst = 1'b0;
    k = cyc;
    push(k + 5, 4'h0, 4'h0, 4'h0, 1'b1, "rst_pre");
    pushl(k + 6, 4'hF, 4'hF, "rst_acc");
    pushl(k + 7, 4'hF, 4'h0, "rst_one");
    run_to(k + 9);

    // Release everything: no strobe on release.
    k = cyc;
    btn_in = 4'hF;
    pushl(k + 5, 4'hF, 4'h0, "relall_pre");
    pushl(k + 6, 4'h0, 4'h0, "relall");
    pushl(k + 7, 4'h0, 4'h0, "relall_post");
    run_to(k + 8);

    // Clean press and release on channel 0.
    k = cyc;
    btn_in = 4'hE;
    pushl(k + 5, 4'h0, 4'h0, "cp_pre");
    pushl(k + 6, 4'h1, 4'h1, "cp_rise");
    pushl(k + 7, 4'h1, 4'h0, "cp_one");
    run_to(k + 9);
    k = cyc;
    btn_in = 4'hF;
    pushl(k + 5, 4'h1, 4'h0, "cprel_pre");
    pushl(k + 6, 4'h0, 4'h0, "cprel");
    pushl(k + 7, 4'h0, 4'h0, "cprel_post");
    run_to(k + 9);

    // 3-cycle glitch on channel 1 is rejected.
    k = cyc;
    btn_in = 4'hD;
    for (int i = 4; i <= 9; i++) pushl(k + i, 4'h0, 4'h0, "glitch3");
    run_to(k + 3);
    btn_in = 4'hF;
    run_to(k + 11);

    // 4-cycle pulse on channel 1 is accepted, then released.
    k = cyc;
    btn_in = 4'hD;
    pushl(k + 5,  4'h0, 4'h0, "pulse4_pre");
    pushl(k + 6,  4'h2, 4'h2, "pulse4_acc");
    pushl(k + 7,  4'h2, 4'h0, "pulse4_one");
    pushl(k + 9,  4'h2, 4'h0, "pulse4_hold");
    pushl(k + 10, 4'h0, 4'h0, "pulse4_rel");
    run_to(k + 4);
    btn_in = 4'hF;
    run_to(k + 12);

    // Simultaneous presses on channels 1 and 3.
    k = cyc;
    btn_in = 4'h5;
    pushl(k + 5, 4'h0, 4'h0, "simul_pre");
    pushl(k + 6, 4'hA, 4'hA, "simul_acc");
    pushl(k + 7, 4'hA, 4'h0, "simul_one");
    run_to(k + 8);
    k = cyc;
    btn_in = 4'hF;
    pushl(k + 5, 4'hA, 4'h0, "simrel_pre");
    pushl(k + 6, 4'h0, 4'h0, "simrel");
    pushl(k + 7, 4'h0, 4'h0, "simrel_post");
    run_to(k + 8);

    // Reset while channel 3 count is at 2; held button re-qualifies 6 cycles after release.
    k = cyc;
    btn_in = 4'h7;
    push(k + 5, 4'h0, 4'h0, 4'h0, 1'b1, "rmc_rst");
    for (int i = 6; i <= 10; i++) push(k + i, 4'h0, 4'h0, 4'h0, 1'b1, "rmc_wait");
    pushl(k + 11, 4'h8, 4'h8, "rmc_acc");
    pushl(k + 12, 4'h8, 4'h0, "rmc_one");
    run_to(k + 4);
    rst = 1'b1;
    run_to(k + 5);
    rst = 1'b0;
    run_to(k + 13);
    k = cyc;
    btn_in = 4'hF;
    pushl(k + 6, 4'h0, 4'h0, "rmc_rel");
    run_to(k + 8);

`ifdef LED_CTRL_TOGGLE_EN
    // Toggle build: three presses on channel 2, held presses give one flip each.
    rst = 1'b1;
    run_to(cyc + 1);
    rst = 1'b0;
    push(cyc, 4'h0, 4'h0, 4'h0, 1'b1, "tg_rst");
    tog = 4'h0;
    for (int p = 0; p < 3; p++) begin
      k = cyc;
      btn_in = 4'hB;
      push(k + 6, 4'h4, 4'h4, tog, 1'b1, "tg_strobe");
      tog = tog ^ 4'h4;
      push(k + 7,  4'h4, 4'h0, tog, 1'b1, "tg_flip");
      push(k + 11, 4'h4, 4'h0, tog, 1'b1, "tg_hold");
      run_to(k + 12);
      k = cyc;
      btn_in = 4'hF;
      push(k + 6, 4'h0, 4'h0, tog, 1'b1, "tg_rel");
      push(k + 7, 4'h0, 4'h0, tog, 1'b1, "tg_rel_post");
      run_to(k + 8);
    end
`else
    tog = 4'h0;
`endif

    // Let the scoreboard drain, bounded.
    for (int i = 0; i < 20 && q_cyc.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("sb_drain", 32'(q_cyc.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
